// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types for the MC14500B I/O access controller
package io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } io_state_t;

  typedef enum logic {
    CPU  = 1'b0,
    HOST = 1'b1
  } io_requester_t;

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - one-bit 2-flop synchroniser followed by a hold-time debouncer
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] L_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Any cycle where the synced value agrees with the accepted one restarts the hold window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == L_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;

endmodule

// File: rtl/io_access_controller.sv
// rtl/io_access_controller.sv - arbitrated CPU/host access to the 1-bit output latches and debounced inputs
module io_access_controller
  import io_pkg::*;
#(
  parameter int ADDR_WIDTH      = 4,
  parameter int OUTPUT_SIZE     = 8,
  parameter int INPUT_SIZE      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_write,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic                   cpu_data_in,
  output logic                   cpu_data_out,
  output logic                   cpu_ack,
  input  logic                   host_req,
  input  logic                   host_write,
  input  logic [ADDR_WIDTH-1:0]  host_addr,
  input  logic                   host_data_in,
  output logic                   host_data_out,
  output logic                   host_ack,
  input  logic [INPUT_SIZE-1:0]  input_pins,
  output logic [OUTPUT_SIZE-1:0] output_pins,
  output logic                   addr_error
);

  localparam int AXW = ADDR_WIDTH + 1;
  localparam logic [AXW-1:0] L_END = AXW'(OUTPUT_SIZE + INPUT_SIZE);

  io_state_t             r_state;
  io_state_t             w_next_state;
  io_requester_t         r_owner;
  io_requester_t         r_rr_last;
  io_requester_t         w_winner;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_data;
  logic [OUTPUT_SIZE-1:0] r_latch;
  logic                  r_cpu_ack;
  logic                  r_host_ack;
  logic                  r_cpu_rdata;
  logic                  r_host_rdata;
  logic                  r_addr_error;
  logic [AXW-1:0]        w_addr_ext;
  logic                  w_rdata;
  logic                  w_bad_addr;
  logic [INPUT_SIZE-1:0] w_debounced;

  genvar g;
  generate
    for (g = 0; g < INPUT_SIZE; g++) begin : g_in
      io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk    (clk),
        .reset  (reset),
        .raw    (input_pins[g]),
        .stable (w_debounced[g])
      );
    end
  endgenerate

  // Round-robin: on contention the requester that did not win last time goes first.
  always_comb begin
    w_next_state = r_state;
    w_winner     = HOST;
    case (r_state)
      IDLE: begin
        if (cpu_req || host_req) begin
          w_next_state = EXEC;
          w_winner     = (cpu_req && (!host_req || r_rr_last == HOST)) ? CPU : HOST;
        end
      end
      EXEC:    w_next_state = ACK;
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Zero-extended address keeps the range compare from wrapping at the top of the space.
  always_comb begin
    w_addr_ext = {1'b0, r_addr};
    w_bad_addr = (w_addr_ext >= L_END);
    w_rdata    = 1'b0;
    for (int i = 0; i < OUTPUT_SIZE; i++) begin
      if (w_addr_ext == AXW'(i)) w_rdata = r_latch[i];
    end
    for (int j = 0; j < INPUT_SIZE; j++) begin
      if (w_addr_ext == AXW'(OUTPUT_SIZE + j)) w_rdata = w_debounced[j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= CPU;
      r_rr_last    <= HOST;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_data       <= 1'b0;
      r_latch      <= '0;
      r_cpu_ack    <= 1'b0;
      r_host_ack   <= 1'b0;
      r_cpu_rdata  <= 1'b0;
      r_host_rdata <= 1'b0;
      r_addr_error <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cpu_ack    <= 1'b0;
      r_host_ack   <= 1'b0;
      r_cpu_rdata  <= 1'b0;
      r_host_rdata <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_next_state == EXEC) begin
            r_owner   <= w_winner;
            r_rr_last <= w_winner;
            r_write   <= (w_winner == CPU) ? cpu_write   : host_write;
            r_addr    <= (w_winner == CPU) ? cpu_addr    : host_addr;
            r_data    <= (w_winner == CPU) ? cpu_data_in : host_data_in;
          end
        end
        EXEC: begin
          if (r_write) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
              if (w_addr_ext == AXW'(i)) r_latch[i] <= r_data;
            end
          end
          if (w_bad_addr) r_addr_error <= 1'b1;
          // Writes complete with data_out held at 0; only reads return data.
          if (r_owner == CPU) begin
            r_cpu_ack   <= 1'b1;
            r_cpu_rdata <= !r_write && w_rdata;
          end else begin
            r_host_ack   <= 1'b1;
            r_host_rdata <= !r_write && w_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_ack       = r_cpu_ack;
  assign host_ack      = r_host_ack;
  assign cpu_data_out  = r_cpu_rdata;
  assign host_data_out = r_host_rdata;
  assign output_pins   = r_latch;
  assign addr_error    = r_addr_error;

endmodule

// File: tb/tb_io_access_controller.sv
// tb/tb_io_access_controller.sv - scoreboard bench for io_access_controller
module tb_io_access_controller;
  import io_pkg::*;

  localparam int AW = 4;
  localparam int OS = 8;
  localparam int IS = 7;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_write, cpu_data_in, cpu_data_out, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic          host_req, host_write, host_data_in, host_data_out, host_ack;
  logic [AW-1:0] host_addr;
  logic [IS-1:0] input_pins;
  logic [OS-1:0] output_pins;
  logic          addr_error;

  typedef struct {
    logic who;
    logic data;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;
  int   lat;

  io_access_controller #(
    .ADDR_WIDTH(AW), .OUTPUT_SIZE(OS), .INPUT_SIZE(IS), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack),
    .host_req(host_req), .host_write(host_write), .host_addr(host_addr),
    .host_data_in(host_data_in), .host_data_out(host_data_out), .host_ack(host_ack),
    .input_pins(input_pins), .output_pins(output_pins), .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic who, input logic wr, input logic [AW-1:0] a,
                       input logic d, input logic exp_data);
    exp_t e;
    e.who  = who;
    e.data = exp_data;
    sb.push_back(e);
    if (who == CPU) begin
      cpu_req = 1'b1; cpu_write = wr; cpu_addr = a; cpu_data_in = d;
    end else begin
      host_req = 1'b1; host_write = wr; host_addr = a; host_data_in = d;
    end
  endtask

  task automatic take_ack(input logic who);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_ack", {cpu_ack, host_ack}, 2'b00);
    end else begin
      e = sb.pop_front();
      check("grant_order", host_ack, e.who);
      check("winner_data", (who == CPU) ? cpu_data_out : host_data_out, e.data);
      check("loser_data_zero", (who == CPU) ? host_data_out : cpu_data_out, 1'b0);
    end
  endtask

  // Steps negedges until every raised request has been acked; first_lat = cycles to first ack.
  task automatic run(input int budget, output int first_lat);
    int cyc = 0;
    bit cpu_done  = !cpu_req;
    bit host_done = !host_req;
    first_lat = -1;
    while (!(cpu_done && host_done) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cpu_ack && host_ack) check("dual_ack", host_ack, 1'b0);
      if (cpu_ack) begin
        take_ack(CPU);
        cpu_req = 1'b0; cpu_done = 1'b1;
        if (first_lat < 0) first_lat = cyc;
      end
      if (host_ack) begin
        take_ack(HOST);
        host_req = 1'b0; host_done = 1'b1;
        if (first_lat < 0) first_lat = cyc;
      end
    end
    if (!(cpu_done && host_done)) check("ack_timeout", {cpu_done, host_done}, 2'b11);
    @(negedge clk);
    check("ack_single_cycle", {cpu_ack, host_ack}, 2'b00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b0; host_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_data_in = 1'b0;
    host_req = 1'b0; host_write = 1'b0; host_addr = '0; host_data_in = 1'b0;
    input_pins = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_host_ack", host_ack, 1'b0);
    check("rst_cpu_data", cpu_data_out, 1'b0);
    check("rst_host_data", host_data_out, 1'b0);
    check("rst_output_pins", output_pins, 8'h00);
    check("rst_addr_error", addr_error, 1'b0);

    // Single CPU write, latency and latch update
    issue(CPU, 1'b1, 4'd3, 1'b1, 1'b0);
    run(10, lat);
    check("write_latency", lat, 2);
    check("write_pins", output_pins, 8'h08);
    issue(CPU, 1'b0, 4'd3, 1'b0, 1'b1);
    run(10, lat);
    issue(HOST, 1'b0, 4'd4, 1'b0, 1'b0);
    run(10, lat);
    check("host_read_latency", lat, 2);

    // Contention: CPU first after reset, then strict alternation
    do_reset();
    issue(CPU, 1'b1, 4'd1, 1'b1, 1'b0);
    issue(HOST, 1'b1, 4'd2, 1'b1, 1'b0);
    run(15, lat);
    check("contend1_lat", lat, 2);
    issue(CPU, 1'b0, 4'd1, 1'b0, 1'b1);
    issue(HOST, 1'b0, 4'd0, 1'b0, 1'b0);
    run(15, lat);
    issue(CPU, 1'b0, 4'd2, 1'b0, 1'b1);
    issue(HOST, 1'b1, 4'd7, 1'b1, 1'b0);
    run(15, lat);
    check("contend_pins", output_pins, 8'h86);

    // Debounced inputs
    input_pins[0] = 1'b1;
    issue(HOST, 1'b0, 4'd8, 1'b0, 1'b0);
    run(10, lat);
    input_pins[2] = 1'b1;
    repeat (8) @(negedge clk);
    issue(HOST, 1'b0, 4'd10, 1'b0, 1'b1);
    run(10, lat);
    input_pins[5] = 1'b1;
    repeat (2) @(negedge clk);
    input_pins[5] = 1'b0;
    repeat (8) @(negedge clk);
    issue(HOST, 1'b0, 4'd13, 1'b0, 1'b0);
    run(10, lat);
    input_pins[6] = 1'b1;
    repeat (8) @(negedge clk);
    issue(CPU, 1'b0, 4'd14, 1'b0, 1'b1);
    run(10, lat);
    issue(CPU, 1'b0, 4'd8, 1'b0, 1'b1);
    run(10, lat);

    // Out-of-range access: acked, reads 0, sticky error
    check("err_before", addr_error, 1'b0);
    issue(CPU, 1'b0, 4'd15, 1'b0, 1'b0);
    run(10, lat);
    check("oor_latency", lat, 2);
    check("err_set", addr_error, 1'b1);
    issue(HOST, 1'b1, 4'd3, 1'b1, 1'b0);
    run(10, lat);
    check("err_sticky", addr_error, 1'b1);
    do_reset();
    check("err_cleared", addr_error, 1'b0);

    // Write into input range is ignored without error
    issue(CPU, 1'b1, 4'd5, 1'b1, 1'b0);
    run(10, lat);
    check("pins_before_inwrite", output_pins, 8'h20);
    issue(CPU, 1'b1, 4'd9, 1'b1, 1'b0);
    run(10, lat);
    check("pins_after_inwrite", output_pins, 8'h20);
    check("inwrite_no_err", addr_error, 1'b0);

    // Reset while a write is in EXEC: abandoned, no ack, latch untouched
    do_reset();
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 4'd0; cpu_data_in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_no_ack", cpu_ack, 1'b0);
    check("abort_pins", output_pins, 8'h00);
    cpu_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("abort_no_ack_after", cpu_ack, 1'b0);
    check("abort_pins_after", output_pins, 8'h00);
    issue(CPU, 1'b0, 4'd0, 1'b0, 1'b0);
    run(10, lat);
    check("post_abort_latency", lat, 2);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
